// File: rtl/score_display_pkg.sv
// Shared constants for the score display: conversion FSM states, seven-segment
// codes (active-low, seg[0]=a .. seg[6]=g), digit-index values and score limits.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int PLAYER_LIVES = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam logic [1:0] DIG_UNITS = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_LIVES = 2'd2;
  localparam logic [1:0] DIG_BLANK = 2'd3;

  localparam logic [6:0] SCORE_MAX = 7'd99;

  // Scores beyond two digits saturate so the display never overflows.
  function automatic logic [6:0] clamp_score(input logic [6:0] s);
    return (s > SCORE_MAX) ? SCORE_MAX : s;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Values 10..15 are not valid digits and decode to all segments off.
module seg7_decoder
  import score_display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Digit lookup
  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed score display: units, tens (leading zero blanked),
// lives, and one always-blank position. Score is converted to BCD by a
// sequential shift-add-3 FSM that reruns whenever the input score changes.
// Optional feature macro SCORE_DISPLAY_BLINK_EN: blink the whole display at
// game over (lives==0).
//
// state | meaning
// IDLE  | waiting for score to differ from the last converted value
// SHIFT | 7 shift-add-3 steps, one score bit per cycle
// DONE  | publish tens/units to the display registers
module score_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] score,
  input  logic [1:0] lives,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam int RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  conv_state_t state;
  logic [6:0]  score_last;
  logic [6:0]  bin_sr;
  logic [7:0]  bcd_sr;
  logic [7:0]  bcd_adj;
  logic [2:0]  bit_cnt;
  logic [3:0]  tens;
  logic [3:0]  units;

  logic [RCNT_W-1:0] refresh_cnt;
  logic [1:0]        digit_idx;
  logic              blank_all;

  logic [3:0] dig_val;
  logic [3:0] an_next;
  logic [6:0] dec_seg;

  // Add 3 to any BCD nibble of 5 or more ahead of the next shift
  always_comb begin
    bcd_adj = bcd_sr;
    if (bcd_sr[3:0] >= 4'd5) bcd_adj[3:0] = bcd_sr[3:0] + 4'd3;
    if (bcd_sr[7:4] >= 4'd5) bcd_adj[7:4] = bcd_sr[7:4] + 4'd3;
  end

  // Binary-to-BCD conversion FSM; display registers only move in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      score_last <= '0;
      bin_sr     <= '0;
      bcd_sr     <= '0;
      bit_cnt    <= '0;
      tens       <= '0;
      units      <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Latch the raw score so an out-of-range value does not retrigger forever
          if (score != score_last) begin
            bin_sr     <= clamp_score(score);
            bcd_sr     <= '0;
            score_last <= score;
            bit_cnt    <= '0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj[6:0], bin_sr, 1'b0};
          bit_cnt          <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd6) state <= DONE;
        end
        DONE: begin
          tens  <= bcd_sr[7:4];
          units <= bcd_sr[3:0];
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit scan: each position held for REFRESH_DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= DIG_UNITS;
    end else if (refresh_cnt == RCNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

`ifdef SCORE_DISPLAY_BLINK_EN
  localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BCNT_W-1:0] blink_cnt;
  logic              blink_phase;

  // Blink half-period timer; phase 1 is the dark half
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BCNT_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blank_all = (lives == 2'd0) && blink_phase;
`else
  // BLINK_DIV has no role without blinking
  logic unused_blink_div;
  assign unused_blink_div = ^BLINK_DIV;
  assign blank_all        = 1'b0;
`endif

  // Select the digit value and its anode for the current scan position
  always_comb begin
    dig_val = 4'd0;
    an_next = 4'hF;
    case (digit_idx)
      DIG_UNITS: begin
        dig_val = units;
        an_next = 4'b1110;
      end
      DIG_TENS: begin
        dig_val = tens;
        an_next = (tens == 4'd0) ? 4'hF : 4'b1101;
      end
      DIG_LIVES: begin
        dig_val = {2'b00, lives};
        an_next = 4'b1011;
      end
      default: begin
        dig_val = 4'd0;
        an_next = 4'hF;
      end
    endcase
  end

  seg7_decoder u_dec (
    .value(dig_val),
    .seg  (dec_seg)
  );

  // Registered outputs; any dark position also drives all segments off
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else if (blank_all || (an_next == 4'hF)) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else begin
      seg <= dec_seg;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display with REFRESH_DIV=4, BLINK_DIV=16.
// Reference model: decimal arithmetic on the clamped score plus a scan
// position derived from the cycle count since reset.
module tb_score_display;

  localparam int RD = 4;
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] score = '0;
  logic [1:0] lives = 2'd3;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int tens_m = 0;
  int units_m = 0;
  int lives_m = 3;
  int last_score = 0;
  logic [6:0] segtab [10];

  score_display #(
    .REFRESH_DIV(RD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .score(score),
    .lives(lives),
    .seg  (seg),
    .an   (an),
    .busy (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs from the model state and cycles elapsed since reset
  task automatic check_scan(input int ncyc);
    int idx;
    bit dark;
    logic [3:0] ea;
    logic [6:0] es;
    for (int i = 0; i < ncyc; i++) begin
      step();
      idx  = ((cyc - 1) / RD) % 4;
      dark = 1'b0;
`ifdef SCORE_DISPLAY_BLINK_EN
      dark = (lives_m == 0) && ((((cyc - 1) / BD) % 2) == 1);
`endif
      ea = 4'hF;
      es = 7'h7F;
      if (!dark) begin
        if (idx == 0) begin
          ea = 4'b1110; es = segtab[units_m];
        end else if (idx == 1 && tens_m != 0) begin
          ea = 4'b1101; es = segtab[tens_m];
        end else if (idx == 2) begin
          ea = 4'b1011; es = segtab[lives_m];
        end
      end
      chk("an", 32'(an), 32'(ea));
      chk("seg", 32'(seg), 32'(es));
      chk("busy_idle", 32'(busy), 32'd0);
    end
  endtask

  // Apply a new score and check busy over the full conversion window
  task automatic convert(input int s);
    int c;
    score = 7'(s);
    last_score = s;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("busy_conv", 32'(busy), 32'd1);
    end
    step();
    chk("busy_end", 32'(busy), 32'd0);
    c = (s > 99) ? 99 : s;
    tens_m  = c / 10;
    units_m = c % 10;
  endtask

  initial begin
    int s;
    segtab[0] = 7'h40; segtab[1] = 7'h79; segtab[2] = 7'h24; segtab[3] = 7'h30;
    segtab[4] = 7'h19; segtab[5] = 7'h12; segtab[6] = 7'h02; segtab[7] = 7'h78;
    segtab[8] = 7'h00; segtab[9] = 7'h10;

    // Reset state
    rst = 1'b1; score = 7'd0; lives = 2'd3; lives_m = 3;
    repeat (3) step();
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    check_scan(16);

    // Basic conversions, including clamp
    convert(42);
    check_scan(16);
    convert(120);
    check_scan(16);

    // Score change mid-conversion: 42 finishes, then 57 runs
    score = 7'd42;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("busy_mid_a", 32'(busy), 32'd1);
    end
    score = 7'd57;
    for (int i = 4; i <= 8; i++) begin
      step();
      chk("busy_mid_a", 32'(busy), 32'd1);
    end
    step();
    chk("busy_gap", 32'(busy), 32'd0);
    for (int i = 10; i <= 17; i++) begin
      step();
      chk("busy_mid_b", 32'(busy), 32'd1);
    end
    step();
    chk("busy_mid_end", 32'(busy), 32'd0);
    last_score = 57; tens_m = 5; units_m = 7;
    check_scan(16);

    // Game over and single life
    lives = 2'd0; lives_m = 0;
    check_scan(32);
    lives = 2'd1; lives_m = 1;
    check_scan(32);

    // Randomized scores and lives
    for (int k = 0; k < 8; k++) begin
      s = int'($urandom_range(0, 127));
      if (s == last_score) s = (s + 1) % 128;
      lives_m = int'($urandom_range(0, 3));
      lives = 2'(lives_m);
      convert(s);
      check_scan(32);
    end

    // Reset during a conversion, then restart straight out of reset
    score = (last_score == 77) ? 7'd78 : 7'd77;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_seg", 32'(seg), 32'h7F);
    chk("rst_mid_an", 32'(an), 32'hF);
    rst = 1'b0;
    tens_m = 0; units_m = 0;
    convert(77);
    check_scan(16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
